// File: rtl/picosoc_timer.sv
// Memory-mapped 32-bit timer for the PicoSoC iomem bus: prescaled up-counter,
// compare match with optional auto-reload, and a level interrupt.
module picosoc_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq_out
);

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_COMPARE  = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  localparam logic [PRESCALE_W-1:0] PRESC_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic                  sel;
  logic [2:0]            off;
  logic                  wr_en;
  logic                  ready_q, ready_d;
  logic                  ack_q, ack_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           rd_val;
  logic [2:0]            ctrl_q, ctrl_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           compare_q, compare_d;
  logic                  match_q, match_d;
  logic                  tick, tick_match;
  logic [31:0]           prescale_ext;
  logic [31:0]           merged;
  logic                  unused_addr_lsbs;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  assign unused_addr_lsbs = ^iomem_addr[1:0];

  always_comb begin
    sel   = iomem_valid && (iomem_addr[31:5] == BASE_ADDR[31:5]);
    off   = iomem_addr[4:2];
    wr_en = ready_q && sel && (iomem_wstrb != 4'b0000);
  end

  always_comb begin
    prescale_ext = '0;
    prescale_ext[PRESCALE_W-1:0] = prescale_q;
    case (off)
      OFF_CTRL:     rd_val = {29'b0, ctrl_q};
      OFF_PRESCALE: rd_val = prescale_ext;
      OFF_COUNT:    rd_val = count_q;
      OFF_COMPARE:  rd_val = compare_q;
      OFF_STATUS:   rd_val = {31'b0, match_q};
      default:      rd_val = '0;
    endcase
  end

  // ack_q remembers that the current request was already answered, so a
  // master that keeps valid high never sees a second ready pulse.
  always_comb begin
    ready_d = sel && !ready_q && !ack_q;
    ack_d   = sel && (ready_q || ack_q);
    rdata_d = ready_d ? rd_val : '0;
  end

  always_comb begin
    tick       = ctrl_q[0] && (presc_cnt_q == prescale_q);
    tick_match = tick && (count_q == compare_q);

    ctrl_d      = ctrl_q;
    prescale_d  = prescale_q;
    compare_d   = compare_q;
    count_d     = count_q;
    match_d     = match_q;
    merged      = '0;
    presc_cnt_d = (!ctrl_q[0] || tick) ? '0 : presc_cnt_q + PRESC_ONE;

    if (tick) begin
      count_d = (tick_match && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;
    end

    // A new match wins over a simultaneous write-1-to-clear.
    if (tick_match) begin
      match_d = 1'b1;
    end else if (wr_en && off == OFF_STATUS && iomem_wstrb[0] && iomem_wdata[0]) begin
      match_d = 1'b0;
    end

    if (wr_en) begin
      case (off)
        OFF_CTRL: begin
          merged = byte_merge({29'b0, ctrl_q}, iomem_wdata, iomem_wstrb);
          ctrl_d = merged[2:0];
        end
        OFF_PRESCALE: begin
          merged      = byte_merge(prescale_ext, iomem_wdata, iomem_wstrb);
          prescale_d  = merged[PRESCALE_W-1:0];
          presc_cnt_d = '0;
        end
        OFF_COUNT: begin
          merged  = byte_merge(count_q, iomem_wdata, iomem_wstrb);
          count_d = merged;
        end
        OFF_COMPARE: begin
          merged    = byte_merge(compare_q, iomem_wdata, iomem_wstrb);
          compare_d = merged;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q     <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      ctrl_q      <= '0;
      prescale_q  <= '0;
      presc_cnt_q <= '0;
      count_q     <= '0;
      compare_q   <= '0;
      match_q     <= 1'b0;
    end else begin
      ready_q     <= ready_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      ctrl_q      <= ctrl_d;
      prescale_q  <= prescale_d;
      presc_cnt_q <= presc_cnt_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      match_q     <= match_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign irq_out     = match_q && ctrl_q[2];

endmodule
